// File: rtl/seg_display_ctrl_if.sv
// Value handshake between application logic and seg_display_ctrl.
// The source drives in_valid/in_data; the controller answers with in_ready/busy.
interface seg_display_ctrl_if #(
    parameter int BIN_W = 14
);
    logic             in_valid;
    logic [BIN_W-1:0] in_data;
    logic             in_ready;
    logic             busy;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output busy
    );
endinterface

// File: rtl/seg_display_ctrl.sv
// Multi-digit 7-segment controller: iterative double-dabble binary-to-BCD plus a scanned shared decoder.
// Optional macro SEG_DISPLAY_BLANK_EN enables leading-zero blanking of the anodes.

module bcd7seg #(
    parameter int ACTIVE_LOW = 1
) (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    // seg[6:0] = {g,f,e,d,c,b,a}; 4'hF renders a dash, other non-decimal codes are dark
    logic [6:0] seg_on;

    always_comb begin
        seg_on = 7'b0000000;
        case (bcd)
            4'd0:    seg_on = 7'b0111111;
            4'd1:    seg_on = 7'b0000110;
            4'd2:    seg_on = 7'b1011011;
            4'd3:    seg_on = 7'b1001111;
            4'd4:    seg_on = 7'b1100110;
            4'd5:    seg_on = 7'b1101101;
            4'd6:    seg_on = 7'b1111101;
            4'd7:    seg_on = 7'b0000111;
            4'd8:    seg_on = 7'b1111111;
            4'd9:    seg_on = 7'b1101111;
            4'hF:    seg_on = 7'b1000000;
            default: seg_on = 7'b0000000;
        endcase
    end

    assign seg = (ACTIVE_LOW != 0) ? ~seg_on : seg_on;
endmodule

module seg_display_ctrl #(
    parameter int NDIG          = 4,
    parameter int BIN_W         = 14,
    parameter int SCAN_DIV      = 50000,
    parameter int ACTIVE_LOW    = 1,
    parameter int AN_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg_display_ctrl_if.slave     bus,
    output logic [4*NDIG-1:0]     bcd_out,
    output logic [6:0]            seg,
    output logic [NDIG-1:0]       an
);
    localparam int ACC_W = 4*NDIG + 4;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t            state_reg;
    logic              in_ready_reg;
    logic [BIN_W-1:0]  bin_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              ovf_reg;
    logic [4*NDIG-1:0] disp_reg;

    logic [PRE_W-1:0]  presc_reg;
    logic [IDX_W-1:0]  idx_reg;

    logic [ACC_W-1:0]  acc_adj;
    logic              acc_ovf;

    // Add-3 correction on every nibble, including the guard nibble above the display
    generate
        for (genvar gi = 0; gi < NDIG + 1; gi++) begin : g_add3
            assign acc_adj[4*gi +: 4] = (acc_reg[4*gi +: 4] >= 4'd5) ?
                                        acc_reg[4*gi +: 4] + 4'd3 :
                                        acc_reg[4*gi +: 4];
        end
    endgenerate

    // Guard nibble nonzero, or a carry already shifted out of it (narrow accumulators)
    assign acc_ovf = ovf_reg || (acc_reg[ACC_W-1 -: 4] != 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            in_ready_reg <= 1'b1;
            bin_reg      <= '0;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            ovf_reg      <= 1'b0;
            disp_reg     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        bin_reg      <= bus.in_data;
                        acc_reg      <= '0;
                        ovf_reg      <= 1'b0;
                        cnt_reg      <= CNT_W'(BIN_W);
                        in_ready_reg <= 1'b0;
                        state_reg    <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    acc_reg <= {acc_adj[ACC_W-2:0], bin_reg[BIN_W-1]};
                    bin_reg <= bin_reg << 1;
                    if (acc_adj[ACC_W-1]) begin
                        ovf_reg <= 1'b1;
                    end
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    disp_reg     <= acc_ovf ? '1 : acc_reg[4*NDIG-1:0];
                    in_ready_reg <= 1'b1;
                    state_reg    <= ST_IDLE;
                end
                default: begin
                    in_ready_reg <= 1'b1;
                    state_reg    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_reg;
    assign bus.busy     = ~in_ready_reg;
    assign bcd_out      = disp_reg;

    // Free-running scan; never reset by conversions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg <= '0;
            idx_reg   <= '0;
        end else if (presc_reg == PRE_W'(SCAN_DIV - 1)) begin
            presc_reg <= '0;
            idx_reg   <= (idx_reg == IDX_W'(NDIG - 1)) ? '0 : idx_reg + IDX_W'(1);
        end else begin
            presc_reg <= presc_reg + PRE_W'(1);
        end
    end

    logic [3:0]      nib [NDIG];
    logic [NDIG-1:0] blank;
    logic [NDIG-1:0] an_on;

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
            assign nib[gi] = disp_reg[4*gi +: 4];
`ifdef SEG_DISPLAY_BLANK_EN
            // A digit is blank when it and every more significant digit are zero
            if (gi == 0) begin : g_keep
                assign blank[gi] = 1'b0;
            end else begin : g_lz
                assign blank[gi] = ~|disp_reg[4*NDIG-1:4*gi];
            end
`else
            assign blank[gi] = 1'b0;
`endif
            assign an_on[gi] = (idx_reg == IDX_W'(gi)) && !blank[gi];
        end
    endgenerate

    assign an = (AN_ACTIVE_LOW != 0) ? ~an_on : an_on;

    bcd7seg #(
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_dec (
        .bcd (nib[idx_reg]),
        .seg (seg)
    );
endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl: reset, idle scan, conversions, overflow, busy-ignore, reset abort.
module tb_seg_display_ctrl;
    logic        clk;
    logic        rst_n;
    logic [15:0] bcd_out;
    logic [6:0]  seg;
    logic [3:0]  an;

    int n_vec = 0;
    int n_err = 0;

    seg_display_ctrl_if #(.BIN_W(14)) bus ();

    seg_display_ctrl #(
        .NDIG          (4),
        .BIN_W         (14),
        .SCAN_DIV      (4),
        .ACTIVE_LOW    (1),
        .AN_ACTIVE_LOW (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .bcd_out (bcd_out),
        .seg     (seg),
        .an      (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Caller is at a negedge; leaves #1 after the handshake edge
    task automatic handshake(input logic [13:0] v);
        int n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hs_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Counts negedges with in_ready low after the handshake edge; ends on the negedge where ready returns
    task automatic wait_done(output int cycles);
        cycles = 0;
        @(negedge clk);
        check("busy_flag", {31'd0, bus.busy}, 32'd1);
        while (!bus.in_ready && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic convert(input logic [13:0] v, input logic [15:0] exp_bcd);
        int c;
        handshake(v);
        wait_done(c);
        check("busy_len", c, 32'd15);
        check("bcd_out", {16'd0, bcd_out}, {16'd0, exp_bcd});
        $display("conv %0d -> bcd_out %h after %0d busy cycles", v, bcd_out, c);
    endtask

    task automatic wait_an(input logic [3:0] exp, input string tag);
        int n = 0;
        while (an !== exp && n < 16) begin
            @(negedge clk);
            n++;
        end
        check(tag, {28'd0, an}, {28'd0, exp});
    endtask

    initial begin
        int          c;
        logic [3:0]  exp_an;

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(negedge clk);

        check("rst_bcd",   {16'd0, bcd_out}, 32'h0);
        check("rst_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_busy",  {31'd0, bus.busy}, 32'd0);
        check("rst_an",    {28'd0, an}, 32'b1110);
        check("rst_seg",   {25'd0, seg}, 32'b1000000);
        $display("reset: bcd_out %h an %b seg %b", bcd_out, an, seg);

        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            exp_an = ~(4'b0001 << ((i / 4) % 4));
            check("idle_an",  {28'd0, an}, {28'd0, exp_an});
            check("idle_seg", {25'd0, seg}, 32'b1000000);
            @(negedge clk);
        end
        check("idle_bcd",   {16'd0, bcd_out}, 32'h0);
        check("idle_ready", {31'd0, bus.in_ready}, 32'd1);
        $display("idle scan: 32 cycles observed");

        convert(14'd1234, 16'h1234);
        wait_an(4'b1011, "d2_an");
        check("d2_seg", {25'd0, seg}, 32'b0100100);
        wait_an(4'b1110, "d0_an");
        check("d0_seg", {25'd0, seg}, 32'b0011001);

        convert(14'd10000, 16'hFFFF);
        for (int d = 0; d < 4; d++) begin
            exp_an = ~(4'b0001 << d);
            wait_an(exp_an, "ovf_an");
            check("ovf_seg", {25'd0, seg}, 32'b0111111);
        end

        // 9999 accepted, then 42 held valid throughout busy; taken only at the first idle edge
        bus.in_valid = 1'b1;
        bus.in_data  = 14'd9999;
        @(posedge clk);
        #1;
        bus.in_data  = 14'd42;
        wait_done(c);
        check("hold_busy_len", c, 32'd15);
        check("hold_bcd_9999", {16'd0, bcd_out}, 32'h9999);
        $display("conv 9999 -> bcd_out %h after %0d busy cycles", bcd_out, c);
        @(negedge clk);
        check("hold_accept42", {31'd0, bus.in_ready}, 32'd0);
        bus.in_valid = 1'b0;
        c = 0;
        while (!bus.in_ready && c < 100) begin
            c++;
            @(negedge clk);
        end
        check("bcd_42", {16'd0, bcd_out}, 32'h0042);
        $display("conv 42 -> bcd_out %h", bcd_out);

        // Reset mid-conversion
        handshake(14'd7);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_bcd",   {16'd0, bcd_out}, 32'h0);
        check("abort_ready", {31'd0, bus.in_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("abort_an", {28'd0, an}, 32'b1110);
        repeat (24) @(negedge clk);
        check("abort_nocommit", {16'd0, bcd_out}, 32'h0);
        check("abort_idle",     {31'd0, bus.in_ready}, 32'd1);
        $display("abort: bcd_out %h in_ready %b", bcd_out, bus.in_ready);

        convert(14'd7, 16'h0007);
`ifdef SEG_DISPLAY_BLANK_EN
        wait_an(4'b1110, "blank_d0_an");
        check("blank_d0_seg", {25'd0, seg}, 32'b1111000);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            check("blank_an", {28'd0, an}, 32'b1111);
            @(negedge clk);
        end
`else
        for (int d = 0; d < 4; d++) begin
            exp_an = ~(4'b0001 << d);
            wait_an(exp_an, "show7_an");
            check("show7_seg", {25'd0, seg}, (d == 0) ? 32'b1111000 : 32'b1000000);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/seg_display_ctrl.md
# seg_display_ctrl

Sequential controller for the multi-digit 7-segment display. It accepts a binary value over a valid/ready handshake and converts it to BCD with an iterative shift-add-3 (double-dabble) engine. It then time-multiplexes one shared `bcd7seg` decoder across `NDIG` digit anodes using a refresh prescaler. It sits between application logic and the board display pins.

## Interface
- `NDIG`, 4: number of display digits, 1..8.
- `BIN_W`, 14: binary input width. Must satisfy 2^BIN_W ≥ 10^NDIG is not required; overflow is handled.
- `SCAN_DIV`, 50000: clock cycles per digit slot, ≥ 2.
- `ACTIVE_LOW`, 1: segment polarity, passed to `bcd7seg`.
- `AN_ACTIVE_LOW`, 1: anode polarity (1 means the enabled anode is driven 0).

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_data` is valid.
- `in_data`  in  `BIN_W`  unsigned value to display.
- `in_ready`  out  1  controller can accept a value.
- `busy`  out  1  conversion in progress; always equals `~in_ready`.
- `bcd_out`  out  `4*NDIG`  committed BCD digits; digit 0 (least significant) in bits [3:0].
- `seg`  out  7  segment bus from the internal `bcd7seg`, using its default mapping.
- `an`  out  `NDIG`  digit anode enables, one-hot or none.

## Operation
- FSM states:
  - IDLE: `in_ready`=1. A handshake (`in_valid`&&`in_ready` at an edge) loads the shift register with `in_data`, clears the BCD accumulator, loads the bit counter with `BIN_W`, and moves to CONV.
  - CONV: each cycle, every BCD nibble ≥5 gets +3, then {bcd, bin} shifts left by 1 and the counter decrements. After `BIN_W` shifts, the FSM moves to COMMIT.
  - COMMIT: writes the accumulator to the display registers, then returns to IDLE.
- The BCD accumulator is `4*NDIG`+4 bits wide. The result is overflow if any nibble above `NDIG-1` is nonzero, i.e. the value is ≥ 10^NDIG. On overflow, all displayed nibbles are 4'hF; `bcd7seg` renders this as a dash (segment g only).
- `in_valid` in CONV or COMMIT is ignored and no data is captured. The source must hold `in_valid` until `in_ready`.
- Scan:
  - The prescaler counts 0..`SCAN_DIV`-1 continuously, independent of the FSM.
  - On wrap, the digit index advances modulo `NDIG`.
  - `an` enables only the indexed digit.
  - The decoder input is the nibble of the indexed digit.
- A display-register update becomes visible in the current slot immediately. Scanning is never stalled or restarted.

## Timing
- Reset values:
  - FSM in IDLE; `in_ready`=1, `busy`=0.
  - `bcd_out`=0; prescaler=0; digit index=0.
  - `an` enables digit 0.
  - `seg` shows the pattern for "0" (for ACTIVE_LOW=1: 7'b1000000).
- Latency: handshake at edge k. Shifts occur at edges k+1..k+`BIN_W`. Commit occurs at edge k+`BIN_W`+1, where `bcd_out` updates and `in_ready` returns to 1. The earliest next handshake is at edge k+`BIN_W`+2.
- Reset asserted mid-conversion aborts it. Display registers return to 0 and the partial result is never committed.
- A digit slot lasts exactly `SCAN_DIV` cycles; a full refresh frame lasts `NDIG*SCAN_DIV` cycles.
- `seg` and `an` are combinational from the registered index and display registers. They change in the same cycle after the index or a commit changes.

## Configuration
- `SEG_DISPLAY_BLANK_EN` defined: leading-zero blanking.
  - During the slot of a digit i>0 whose nibble and all higher nibbles are 0, `an` is all-disabled.
  - Digit 0 is never blanked.
  - Dashes (overflow) are never blanked.
  - `bcd_out` is unaffected.
- Not defined: every digit slot always enables its anode.

## Test plan
Use NDIG=4, BIN_W=14, SCAN_DIV=4, ACTIVE_LOW=1, AN_ACTIVE_LOW=1.
- Reset, then idle 32 cycles: `bcd_out`=16'h0000, `in_ready`=1, `an` cycles 4'b1110→1101→1011→0111 every 4 cycles, and `seg`=7'b1000000 in every slot.
- Handshake 1234: `in_ready`=0 for 15 cycles, then `bcd_out`=16'h1234. In digit 2's slot, `seg`=7'b0100100 (decoded 2).
- Handshake 10000: `bcd_out`=16'hFFFF and `seg`=7'b0111111 in all four slots.
- Handshake 9999, then pulse `in_valid` with 42 while busy: the 42 is ignored, `bcd_out`=16'h9999, and 42 is accepted only after `in_ready` returns.
- Handshake 7, then assert `rst_n`=0 at cycle k+5: `bcd_out`=0 and `in_ready`=1 on release, with no later commit of 7.
- With `SEG_DISPLAY_BLANK_EN`, handshake 7: `an`=4'b1111 in slots 1..3 and 4'b1110 in slot 0. Without the macro, all four slots enable their anode and show "0007".
